// File: rtl/mul_arbiter.sv
// mul_arbiter: round-robin two-port front end for a shared
// combinational 32x32 signed multiplier with HI/LO capture.
module mul_arbiter #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        i_clock,
   input  logic        i_reset,
   input  logic        i_req0_valid,
   output logic        o_req0_ready,
   input  logic [31:0] i_req0_x,
   input  logic [31:0] i_req0_y,
   input  logic        i_req1_valid,
   output logic        o_req1_ready,
   input  logic [31:0] i_req1_x,
   input  logic [31:0] i_req1_y,
   output logic [31:0] o_mul_x,
   output logic [31:0] o_mul_y,
   input  logic [63:0] i_mul_p,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic [1:0]  o_resp_valid,
   output logic        o_busy
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [3:0] LP_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      r_state;
   logic        r_last_grant;
   logic        r_grant;
   logic [3:0]  r_cnt;
   logic [31:0] r_mul_x;
   logic [31:0] r_mul_y;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [1:0]  r_resp_valid;
   logic        r_busy;

   logic w_idle;
   logic w_gnt0;
   logic w_gnt1;
   logic w_hs0;
   logic w_hs1;

   // Reset gates ready so a handshake can never win over reset.
   assign w_idle = (r_state == S_IDLE) & ~i_reset;

   // On a tie the port that did not win last time is picked.
   assign w_gnt0 = i_req0_valid & (~i_req1_valid | r_last_grant);
   assign w_gnt1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

   assign o_req0_ready = w_idle & w_gnt0;
   assign o_req1_ready = w_idle & w_gnt1;

   assign w_hs0 = i_req0_valid & o_req0_ready;
   assign w_hs1 = i_req1_valid & o_req1_ready;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state      <= S_IDLE;
         r_last_grant <= 1'b1;
         r_grant      <= 1'b0;
         r_cnt        <= 4'd0;
         r_mul_x      <= 32'd0;
         r_mul_y      <= 32'd0;
         r_hi         <= 32'd0;
         r_lo         <= 32'd0;
         r_resp_valid <= 2'b00;
         r_busy       <= 1'b0;
      end else begin
         r_resp_valid <= 2'b00;
         unique case (r_state)
            S_IDLE: begin
               if (w_hs0 | w_hs1) begin
                  r_mul_x      <= w_hs1 ? i_req1_x : i_req0_x;
                  r_mul_y      <= w_hs1 ? i_req1_y : i_req0_y;
                  r_grant      <= w_hs1;
                  r_last_grant <= w_hs1;
                  r_cnt        <= LP_LOAD;
                  r_state      <= S_BUSY;
                  r_busy       <= 1'b1;
               end
            end
            S_BUSY: begin
               if (r_cnt == 4'd0) begin
                  r_hi         <= i_mul_p[63:32];
                  r_lo         <= i_mul_p[31:0];
                  r_resp_valid <= r_grant ? 2'b10 : 2'b01;
                  r_state      <= S_RESP;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end
            S_RESP: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_mul_x      = r_mul_x;
   assign o_mul_y      = r_mul_y;
   assign o_hi         = r_hi;
   assign o_lo         = r_lo;
   assign o_resp_valid = r_resp_valid;
   assign o_busy       = r_busy;

endmodule

// File: tb/tb_mul_arbiter.sv
// tb_mul_arbiter: randomized scoreboard bench for mul_arbiter
// against a cycle-count reference model of the arbiter.
module tb_mul_arbiter;

   localparam int WC = 2;

   logic        clk;
   logic        rst;
   logic        v0;
   logic        v1;
   logic [31:0] x0;
   logic [31:0] y0;
   logic [31:0] x1;
   logic [31:0] y1;
   logic        rdy0;
   logic        rdy1;
   logic [31:0] mx;
   logic [31:0] my;
   logic [63:0] mp;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [1:0]  rv;
   logic        busy;

   mul_arbiter #(.WAIT_CYCLES(WC)) dut (
      .i_clock      (clk),
      .i_reset      (rst),
      .i_req0_valid (v0),
      .o_req0_ready (rdy0),
      .i_req0_x     (x0),
      .i_req0_y     (y0),
      .i_req1_valid (v1),
      .o_req1_ready (rdy1),
      .i_req1_x     (x1),
      .i_req1_y     (y1),
      .o_mul_x      (mx),
      .o_mul_y      (my),
      .i_mul_p      (mp),
      .o_hi         (hi),
      .o_lo         (lo),
      .o_resp_valid (rv),
      .o_busy       (busy)
   );

   // Stand-in for the shared combinational multiplier.
   assign mp = 64'(longint'($signed(mx)) * longint'($signed(my)));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] x;
      logic [31:0] y;
   } op_t;

   typedef struct {
      int          id;
      logic [63:0] p;
      int          due;
   } exp_t;

   op_t  q0[$];
   op_t  q1[$];
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
      end
   endtask

   // Reference model: block is idle from cycle m_free on.
   int          m_free = 0;
   bit          m_last = 1'b1;
   logic [31:0] m_x    = '0;
   logic [31:0] m_y    = '0;
   logic [31:0] m_hi   = '0;
   logic [31:0] m_lo   = '0;

   always @(negedge clk) begin
      bit   idle;
      bit   e0;
      bit   e1;
      exp_t e;
      idle = (cyc >= m_free);
      e0   = 1'b0;
      e1   = 1'b0;
      if (idle && !rst) begin
         if (v0 && v1) begin
            e0 = m_last;
            e1 = !m_last;
         end else begin
            e0 = v0;
            e1 = v1;
         end
      end
      chk("ready0", rdy0, e0);
      chk("ready1", rdy1, e1);
      chk("ready_excl", rdy0 & rdy1, 0);
      chk("busy", busy, !idle);
      chk("mul_x", mx, m_x);
      chk("mul_y", my, m_y);
      if (rst) begin
         m_free = cyc + 1;
         m_last = 1'b1;
         m_x    = '0;
         m_y    = '0;
         for (int i = sb.size() - 1; i >= 0; i--)
            if (sb[i].due > cyc) sb.delete(i);
      end else if (e0 || e1) begin
         e.id   = e1 ? 1 : 0;
         m_x    = e1 ? x1 : x0;
         m_y    = e1 ? y1 : y0;
         e.p    = 64'(longint'($signed(m_x)) * longint'($signed(m_y)));
         e.due  = cyc + WC + 1;
         m_free = cyc + WC + 2;
         m_last = e1;
         sb.push_back(e);
      end
   end

   // Monitor: pops the scoreboard whenever a response strobe appears.
   always @(negedge clk) begin
      exp_t e;
      if (rv != 2'b00) begin
         if (sb.size() == 0) begin
            chk("resp_unexpected", rv, 2'b00);
         end else begin
            e = sb.pop_front();
            chk("resp_id", rv, (e.id == 1) ? 2'b10 : 2'b01);
            chk("resp_cycle", cyc, e.due);
            m_hi = e.p[63:32];
            m_lo = e.p[31:0];
         end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         chk("resp_missing", rv, (e.id == 1) ? 2'b10 : 2'b01);
      end
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
      if (rst) begin
         m_hi = '0;
         m_lo = '0;
      end
   end

   bit hs0;
   bit hs1;

   task automatic drive();
      v0 = (q0.size() != 0);
      v1 = (q1.size() != 0);
      if (v0) begin
         x0 = q0[0].x;
         y0 = q0[0].y;
      end
      if (v1) begin
         x1 = q1[0].x;
         y1 = q1[0].y;
      end
   endtask

   task automatic step();
      @(negedge clk);
      hs0 = v0 & rdy0;
      hs1 = v1 & rdy1;
      @(posedge clk);
      #1;
      if (hs0) void'(q0.pop_front());
      if (hs1) void'(q1.pop_front());
      drive();
   endtask

   task automatic push(int id, logic [31:0] x, logic [31:0] y);
      op_t o;
      o.x = x;
      o.y = y;
      if (id == 0) q0.push_back(o);
      else q1.push_back(o);
      drive();
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((q0.size() || q1.size() || sb.size() || busy) && k < 2000) begin
         step();
         k++;
      end
      chk("drain_timeout", k < 2000, 1);
      step();
   endtask

   task automatic wait_busy();
      int k;
      k = 0;
      while (!busy && k < 50) begin
         step();
         k++;
      end
      chk("busy_timeout", busy, 1);
   endtask

   function automatic logic [31:0] rnd_op();
      case ($urandom_range(0, 6))
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'hFFFF_FFFF;
         3: return 32'h0000_0000;
         default: return $urandom();
      endcase
   endfunction

   initial begin
      rst = 1'b1;
      v0  = 1'b0;
      v1  = 1'b0;
      x0  = '0;
      y0  = '0;
      x1  = '0;
      y1  = '0;
      // Tie: both valid while reset is still asserted.
      push(0, 32'd3, 32'd5);
      push(1, -32'sd2, -32'sd4);
      repeat (3) step();
      chk("rst_mul_x", mx, 0);
      chk("rst_mul_y", my, 0);
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_resp", rv, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready0", rdy0, 0);
      chk("rst_ready1", rdy1, 0);
      rst = 1'b0;
      drain();
      chk("tie_hi", hi, 32'h0);
      chk("tie_lo", lo, 32'd8);

      push(0, 32'd7, -32'sd3);
      drain();
      chk("single_hi", hi, 32'hFFFF_FFFF);
      chk("single_lo", lo, 32'hFFFF_FFEB);

      push(0, 32'h8000_0000, 32'h8000_0000);
      drain();
      chk("ext1_hi", hi, 32'h4000_0000);
      chk("ext1_lo", lo, 32'h0);
      push(1, 32'h7FFF_FFFF, 32'h8000_0000);
      drain();
      chk("ext2_hi", hi, 32'hC000_0000);
      chk("ext2_lo", lo, 32'h8000_0000);

      for (int i = 0; i < 3; i++) begin
         push(0, rnd_op(), rnd_op());
         push(1, rnd_op(), rnd_op());
      end
      drain();

      // Reset in the second BUSY cycle aborts the op.
      push(0, 32'd11, 32'd13);
      wait_busy();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_hi", hi, 0);
      chk("abort_lo", lo, 0);
      chk("abort_resp", rv, 0);
      push(0, 32'd11, 32'd13);
      drain();
      chk("reissue_lo", lo, 32'd143);

      // req1 asks while busy, then withdraws before IDLE.
      push(0, 32'd5, 32'd6);
      wait_busy();
      push(1, 32'd9, 32'd9);
      chk("blocked_ready1", rdy1, 0);
      step();
      chk("blocked_ready1b", rdy1, 0);
      q1.delete();
      drive();
      drain();
      chk("withdraw_lo", lo, 32'd30);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 3))
            0: push(0, rnd_op(), rnd_op());
            1: push(1, rnd_op(), rnd_op());
            2: begin
               push(0, rnd_op(), rnd_op());
               push(1, rnd_op(), rnd_op());
            end
            default: ;
         endcase
         repeat ($urandom_range(0, 6)) step();
      end
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout cyc=%0d", cyc);
      $fatal(1);
   end

endmodule
